// File: rtl/seq_mul_pkg.sv
// Shared constants for the sequential shift-and-add multiplier:
// FSM state encoding and the default operand width.
package seq_mul_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CALC = 2'b01;
  localparam logic [1:0] FIX  = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle between an operand source (master)
// and the sequential multiplier (slave).
interface seq_mul_if
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, a_in, b_in,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a_in, b_in,
    output busy, done, product
  );

endinterface

// File: rtl/seq_mul_datapath.sv
// Shift-and-add datapath: magnitude capture, accumulate/shift steps and the
// sign-fixed product register, driven by load/step/fix strobes.
module seq_mul_datapath
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               b_next_zero,
  output logic               cnt_last,
  output logic [2*WIDTH-1:0] product
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH);

  logic [2*WIDTH-1:0] a_sh;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_reg;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  always_comb begin
    a_mag = (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
    b_mag = (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      acc   <= '0;
      b_reg <= '0;
      cnt   <= CNT_INIT;
      neg   <= 1'b0;
    end else if (load) begin
      a_sh  <= {{WIDTH{1'b0}}, a_mag};
      acc   <= '0;
      b_reg <= b_mag;
      cnt   <= CNT_INIT;
      neg   <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
    end else if (step) begin
      if (b_reg[0]) acc <= acc + a_sh;
      a_sh  <= a_sh << 1;
      b_reg <= b_reg >> 1;
      cnt   <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      product <= '0;
    else if (fix) product <= neg ? -acc : acc;
  end

  assign b_next_zero = (b_reg >> 1) == '0;
  assign cnt_last    = cnt == CW'(1);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned multiplier top: IDLE/CALC/FIX/DONE control FSM
// with early termination, driving the shift-and-add datapath.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic   clk,
  input logic   rst,
  seq_mul_if.slave bus
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       load;
  logic       step;
  logic       fix;
  logic       b_next_zero;
  logic       cnt_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          // Only b_in == 0 has a zero magnitude, so skip straight to FIX.
          state_nxt = (bus.b_in == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (b_next_zero || cnt_last) state_nxt = FIX;
      end
      FIX: begin
        fix       = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  seq_mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .fix         (fix),
    .signed_mode (bus.signed_mode),
    .a_in        (bus.a_in),
    .b_in        (bus.b_in),
    .b_next_zero (b_next_zero),
    .cnt_last    (cnt_last),
    .product     (bus.product)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=8): directed cases plus
// random operands checked against an integer-arithmetic reference model.
module tb_seq_multiplier;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_mul_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] last_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: product from plain integer multiplication, latency from the
  // bit length of |b|.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sm, output int lat,
                                output logic [2*W-1:0] p);
    longint sa, sb, full, mag;
    int k;
    sa   = sm ? longint'($signed(a)) : longint'({1'b0, a});
    sb   = sm ? longint'($signed(b)) : longint'({1'b0, b});
    full = sa * sb;
    p    = full[2*W-1:0];
    mag  = (sb < 0) ? -sb : sb;
    k    = 0;
    while (mag > 0) begin
      k++;
      mag = mag >> 1;
    end
    lat = k + 2;
  endfunction

  // Called at a negedge with the DUT idle; that cycle is cycle 0.
  // start_mask bit c pulses start in cycle c; rst_cyc > 0 asserts rst in that cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sm, input int lat, input logic [2*W-1:0] exp_p,
                        input int start_mask, input int rst_cyc);
    int dones;
    dones           = 0;
    bus.start       = 1'b1;
    bus.a_in        = a;
    bus.b_in        = b;
    bus.signed_mode = sm;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      check({tag, " busy"}, 32'(bus.busy), 32'(c <= lat));
      check({tag, " done"}, 32'(bus.done), 32'(c == lat));
      check({tag, " product"}, 32'(bus.product), 32'((c >= lat) ? exp_p : last_p));
      if (bus.done) dones++;
      bus.start       = start_mask[c];
      bus.a_in        = W'($urandom);
      bus.b_in        = W'($urandom);
      bus.signed_mode = 1'($urandom);
      if (c == rst_cyc) begin
        rst = 1'b1;
        @(negedge clk);
        check({tag, " rst busy"}, 32'(bus.busy), 32'd0);
        check({tag, " rst done"}, 32'(bus.done), 32'd0);
        check({tag, " rst product"}, 32'(bus.product), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        last_p    = '0;
        return;
      end
    end
    check({tag, " done count"}, 32'(dones), 32'd1);
    last_p = exp_p;
  endtask

  initial begin
    int lat;
    logic [2*W-1:0] p;
    logic [W-1:0] a, b;
    logic sm;

    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a_in        = '0;
    bus.b_in        = '0;
    last_p          = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("u13x11",   8'd13,  8'd11,  1'b0, 6,  16'h008F, 0, 0);
    run_op("s-3x5",    8'hFD,  8'h05,  1'b1, 5,  16'hFFF1, 0, 0);
    run_op("u200x0",   8'd200, 8'd0,   1'b0, 2,  16'h0000, 0, 0);
    run_op("s7x0",     8'd7,   8'd0,   1'b1, 2,  16'h0000, 0, 0);
    run_op("u255x255", 8'hFF,  8'hFF,  1'b0, 10, 16'hFE01, 0, 0);
    run_op("s-128sq",  8'h80,  8'h80,  1'b1, 10, 16'h4000, 0, 0);
    run_op("ign start", 8'd13, 8'd11,  1'b0, 6,  16'h008F, (1 << 2) | (1 << 6), 0);
    run_op("mid rst",  8'hFF,  8'hFF,  1'b0, 10, 16'hFE01, 0, 3);
    run_op("post rst", 8'd13,  8'd11,  1'b0, 6,  16'h008F, 0, 0);

    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      sm = 1'($urandom);
      case ($urandom_range(0, 4))
        0: b = W'($urandom_range(0, 3));
        1: a = sm ? 8'h80 : 8'hFF;
        2: b = sm ? 8'h80 : 8'hFF;
        default: ;
      endcase
      model(a, b, sm, lat, p);
      run_op($sformatf("rand%0d", i), a, b, sm, lat, p, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
